pulse_train_gen: RTL and testbench
==================================

// Module: pulse_train_gen
// PURPOSE
//   Inverse of the enable-driven up-counter: accepts a binary count N over a
//   valid/ready handshake and emits exactly N single-cycle pulses on `pulse`.
//   Feeding `pulse` into the counter's enable input therefore reproduces N.
//   Used as a stimulus source for count-driven blocks and for pacing
//   N-event bursts at a programmable spacing.
// PARAMETERS
//   WIDTH  3  bit width of the requested count; maximum N = 2**WIDTH-1
//   GAP    1  low cycles inserted between consecutive pulses; 0 = back-to-back
// PORTS
//   clock_reset  in   2      [0] = clock, rising edge; [1] = reset_n, asynchronous, active-low
//   data         in   WIDTH  requested pulse count N
//   valid        in   1      data valid
//   ready        out  1      block can accept a request; high only in IDLE
//   pulse        out  1      one-cycle output pulses
//   done         out  1      one-cycle strobe after the final pulse of a request
//   remaining    out  WIDTH  pulses not yet completed, including the current one
// BEHAVIOUR
//   - States: IDLE, PULSE, SPACE, DONE. State, cnt[WIDTH-1:0] and the gap
//     counter are registers.
//   - pulse = (state==PULSE), done = (state==DONE), ready = (state==IDLE),
//     remaining = cnt. All outputs are decoded from registers only; there is
//     no combinational path from any input to any output.
//   - Reset (clock_reset[1]=0): asynchronously forces state=IDLE, cnt=0 and
//     the gap counter to 0. Outputs are then pulse=0, done=0, remaining=0,
//     ready=1. No request is accepted while reset is low.
//   - IDLE: a request is accepted at a rising edge where valid=1 and ready=1.
//     N!=0: cnt<=N, next state PULSE. N==0: cnt stays 0, next state DONE.
//   - PULSE: lasts one cycle. At the edge, cnt<=cnt-1.
//       If cnt==1, next state is DONE.
//       Else if GAP==0, next state is PULSE.
//       Else the gap counter loads GAP-1 and the next state is SPACE.
//   - SPACE: the gap counter decrements each cycle; next state is PULSE when
//     it reaches 0. SPACE therefore lasts exactly GAP cycles.
//   - DONE: lasts one cycle; next state is IDLE.
//   - Latency: the first pulse occurs in the cycle immediately after the
//     accepting edge. For N>0, accept-to-ready takes N + (N-1)*GAP + 1
//     cycles. For N==0 it takes 1 cycle (the DONE cycle).
//   - valid/data are ignored outside IDLE. A held valid is accepted at the
//     first IDLE edge, so at least one ready-high cycle separates two
//     requests.
//   - cnt never wraps: it is loaded with N <= 2**WIDTH-1 and only counts
//     down to 0.
//   - Reset mid-burst aborts immediately: pulse falls asynchronously and no
//     done strobe is issued. The lost pulses are not resumed after reset
//     releases.
// TESTING (default WIDTH=3 unless stated)
//   1 Hold reset_n=0 with clock toggling -> pulse=0, done=0, remaining=0,
//     ready=1; valid=1 is ignored.
//   2 GAP=1, accept N=3 -> pulse per cycle 1,0,1,0,1; remaining 3,2,2,1,1;
//     then done=1 (remaining 0); ready=1 on the following cycle.
//   3 Accept N=0 -> no pulse; done=1 in the cycle after accept; ready=1 the
//     cycle after that.
//   4 GAP=0, accept N=7 -> 7 consecutive pulse cycles; done on the 8th
//     cycle; a pulse-enabled 3-bit counter ends at 3'b111.
//   5 GAP=1, N=5, drop reset_n mid-clock after 2 pulses -> pulse=0 with no
//     clock edge; done never asserts; after release, N=2 yields exactly 2
//     pulses.
//   6 Hold valid=1 with data changing while busy -> ready=0, requests are
//     ignored; the value present at the first IDLE edge is the one accepted.

Source files
------------

// File: rtl/pulse_train_gen.sv
// pulse_train_gen
// Accepts a pulse count N over a valid/ready handshake and emits exactly N
// single-cycle pulses, spaced by GAP low cycles, followed by a one-cycle
// done strobe. All outputs are decoded from registers only.

module pulse_train_gen #(
    parameter int WIDTH = 3,
    parameter int GAP   = 1
) (
    input  logic [1:0]       clock_reset,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             pulse,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    // Gap counter only needs to hold GAP-1; keep at least one bit.
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_SPACE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic clk_s;
    logic rst_n_s;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic [GW-1:0]    gap_r;
    logic [GW-1:0]    gap_nxt_s;

    assign clk_s   = clock_reset[0];
    assign rst_n_s = clock_reset[1];

    // Next-state logic: handshake accept, pulse countdown and gap spacing.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        gap_nxt_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (valid) begin
                    if (data != {WIDTH{1'b0}}) begin
                        cnt_nxt_s   = data;
                        state_nxt_s = ST_PULSE;
                    end else begin
                        // Zero-length request still produces a done strobe.
                        cnt_nxt_s   = {WIDTH{1'b0}};
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                cnt_nxt_s = cnt_r - WIDTH'(1);
                if (cnt_r == WIDTH'(1)) begin
                    state_nxt_s = ST_DONE;
                end else if (GAP == 0) begin
                    state_nxt_s = ST_PULSE;
                end else begin
                    gap_nxt_s   = GAP_LOAD;
                    state_nxt_s = ST_SPACE;
                end
            end
            ST_SPACE: begin
                // Loaded with GAP-1, so SPACE spans exactly GAP cycles.
                if (gap_r == {GW{1'b0}}) begin
                    state_nxt_s = ST_PULSE;
                end else begin
                    gap_nxt_s   = gap_r - GW'(1);
                    state_nxt_s = ST_SPACE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {WIDTH{1'b0}};
                gap_nxt_s   = {GW{1'b0}};
            end
        endcase
    end

    // State, count and gap registers; reset aborts any burst immediately.
    always_ff @(posedge clk_s or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= {WIDTH{1'b0}};
            gap_r   <= {GW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            gap_r   <= gap_nxt_s;
        end
    end

    assign ready     = (state_r == ST_IDLE);
    assign pulse     = (state_r == ST_PULSE);
    assign done      = (state_r == ST_DONE);
    assign remaining = cnt_r;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: one GAP=1 and one GAP=0 instance,
// an arithmetic per-cycle model, and directed hand-computed checks.

module tb_pulse_train_gen;

    typedef struct packed {
        logic       pulse;
        logic       done;
        logic       ready;
        logic [2:0] rem;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] data = 3'd0;
    logic       valid0 = 1'b0;
    logic       valid1 = 1'b0;

    logic       ready0, pulse0, done0;
    logic [2:0] rem0;
    logic       ready1, pulse1, done1;
    logic [2:0] rem1;

    int tests = 0;
    int fails = 0;

    pulse_train_gen #(.WIDTH(3), .GAP(0)) dut_g0 (
        .clock_reset ({rst_n, clk}),
        .data        (data),
        .valid       (valid0),
        .ready       (ready0),
        .pulse       (pulse0),
        .done        (done0),
        .remaining   (rem0)
    );

    pulse_train_gen #(.WIDTH(3), .GAP(1)) dut_g1 (
        .clock_reset ({rst_n, clk}),
        .data        (data),
        .valid       (valid1),
        .ready       (ready1),
        .pulse       (pulse1),
        .done        (done1),
        .remaining   (rem1)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs t cycles after accepting N (t=1 is the first cycle).
    function automatic obs_t expf(input bit busy, input int n, input int t, input int gap);
        obs_t o;
        int len;
        int j;
        int ph;
        o = '{pulse: 1'b0, done: 1'b0, ready: 1'b1, rem: 3'd0};
        if (busy) begin
            o.ready = 1'b0;
            len = (n == 0) ? 0 : n + (n - 1) * gap;
            if (t <= len) begin
                j  = (t - 1) / (1 + gap);
                ph = (t - 1) % (1 + gap);
                o.pulse = (ph == 0);
                o.rem   = (ph == 0) ? 3'(n - j) : 3'(n - j - 1);
            end else begin
                o.done = 1'b1;
            end
        end
        return o;
    endfunction

    // Behavioural model state: per instance busy flag, accepted N, cycle index.
    bit busy_m[2];
    int n_m[2];
    int t_m[2];

    // Model update: accept when idle and valid, retire after the done cycle.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            int gap;
            int last;
            logic vk;
            gap = (k == 0) ? 0 : 1;
            vk  = (k == 0) ? valid0 : valid1;
            if (!rst_n) begin
                busy_m[k] = 1'b0;
            end else if (busy_m[k]) begin
                last = (n_m[k] == 0) ? 1 : n_m[k] + (n_m[k] - 1) * gap + 1;
                t_m[k] = t_m[k] + 1;
                if (t_m[k] > last) busy_m[k] = 1'b0;
            end else if (vk) begin
                busy_m[k] = 1'b1;
                n_m[k]    = int'(data);
                t_m[k]    = 1;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("model_g0", {pulse0, done0, ready0, rem0}, expf(busy_m[0], n_m[0], t_m[0], 0));
        check("model_g1", {pulse1, done1, ready1, rem1}, expf(busy_m[1], n_m[1], t_m[1], 1));
    end

    // Free-running event counters used by the directed checks.
    logic [2:0] cnt3_0 = 3'd0;
    int pc1 = 0;
    int dc1 = 0;
    always @(posedge clk) begin
        if (pulse0) cnt3_0 <= cnt3_0 + 3'd1;
        if (pulse1) pc1 <= pc1 + 1;
        if (done1) dc1 <= dc1 + 1;
    end

    task automatic req(input int k, input logic [2:0] n);
        data = n;
        if (k == 0) valid0 = 1'b1; else valid1 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    // Directed stimulus.
    initial begin
        logic [2:0] base3;
        int pbase;
        int dbase;
        int ep[5];
        int er[5];
        ep = '{1, 0, 1, 0, 1};
        er = '{3, 2, 2, 1, 1};

        // 1: reset held, valid ignored
        rst_n = 1'b0; valid1 = 1'b1; valid0 = 1'b1; data = 3'd5;
        repeat (4) @(negedge clk);
        check("rst_ready", 32'(ready1), 32'd1);
        check("rst_pulse", 32'(pulse1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_rem", 32'(rem1), 32'd0);
        check("rst_ready_g0", 32'(ready0), 32'd1);
        valid0 = 1'b0; valid1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // 2: GAP=1, N=3
        req(1, 3'd3);
        for (int i = 0; i < 5; i++) begin
            check("n3_pulse", 32'(pulse1), 32'(ep[i]));
            check("n3_rem", 32'(rem1), 32'(er[i]));
            @(negedge clk);
        end
        check("n3_done", 32'(done1), 32'd1);
        check("n3_done_rem", 32'(rem1), 32'd0);
        @(negedge clk);
        check("n3_ready", 32'(ready1), 32'd1);

        // 3: N=0
        req(1, 3'd0);
        check("n0_done", 32'(done1), 32'd1);
        check("n0_nopulse", 32'(pulse1), 32'd0);
        @(negedge clk);
        check("n0_ready", 32'(ready1), 32'd1);

        // 4: GAP=0, N=7 back-to-back
        base3 = cnt3_0;
        req(0, 3'd7);
        repeat (7) @(negedge clk);
        check("n7_done", 32'(done0), 32'd1);
        check("n7_count", 32'(cnt3_0 - base3), 32'd7);
        @(negedge clk);
        check("n7_ready", 32'(ready0), 32'd1);

        // 5: reset mid-burst after two pulses
        dbase = dc1;
        req(1, 3'd5);
        @(negedge clk);
        @(negedge clk);
        check("abort_pre", 32'(pulse1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_pulse", 32'(pulse1), 32'd0);
        check("abort_rem", 32'(rem1), 32'd0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_nodone", 32'(dc1 - dbase), 32'd0);
        pbase = pc1;
        req(1, 3'd2);
        repeat (6) @(negedge clk);
        check("after_pulses", 32'(pc1 - pbase), 32'd2);
        check("after_done", 32'(dc1 - dbase), 32'd1);

        // 6: held valid with changing data while busy
        data = 3'd4; valid1 = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            check("busy_ready", 32'(ready1), 32'd0);
            data = 3'((i % 5) + 1);
            @(negedge clk);
        end
        check("idle_ready", 32'(ready1), 32'd1);
        data = 3'd6;
        @(negedge clk);
        valid1 = 1'b0;
        check("held_rem", 32'(rem1), 32'd6);
        check("held_pulse", 32'(pulse1), 32'd1);
        repeat (14) @(negedge clk);
        check("held_ready", 32'(ready1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
